// File: rtl/car_alarm_pkg.sv
// Shared types and helpers for the car alarm controller.
// State encoding, plus a max() used to size the timer.
package car_alarm_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_ENTRY    = 2'd2,
    ST_ALARM    = 2'd3
  } alarm_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter for entry delay and siren bursts.
// Ports: clk, reset (sync, high), load/load_val, en (decrement), zero.
module alarm_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/car_alarm_fsm.sv
// Car alarm: arm/disarm, entry delay, timed siren with re-trigger.
// Ports: clk, reset (sync, high), CarLightsOnSign, OpenDoorSign,
// IgnitionSignalOn, ArmReq, DisarmReq -> CarAlarmSignal,
// LightsWarning, Armed, TripDoor (all registered).
// Define CAR_ALARM_PULSE_EN for a toggling siren in ALARM.
module car_alarm_fsm
  import car_alarm_pkg::*;
#(
  parameter int NUM_DOORS   = 4,
  parameter int ENTRY_DELAY = 8,
  parameter int ALARM_LEN   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 CarLightsOnSign,
  input  logic [NUM_DOORS-1:0] OpenDoorSign,
  input  logic                 IgnitionSignalOn,
  input  logic                 ArmReq,
  input  logic                 DisarmReq,
  output logic                 CarAlarmSignal,
  output logic                 LightsWarning,
  output logic                 Armed,
  output logic [NUM_DOORS-1:0] TripDoor
);

  localparam int CNT_W =
    $clog2(max_int(ENTRY_DELAY, ALARM_LEN) + 1);
  localparam logic [CNT_W-1:0] ENTRY_LD =
    CNT_W'(ENTRY_DELAY - 1);
  localparam logic [CNT_W-1:0] ALARM_LD =
    CNT_W'(ALARM_LEN - 1);

  alarm_state_e         state_q, state_d;
  logic                 siren_q, siren_d;
  logic                 warn_q, warn_d;
  logic                 armed_q, armed_d;
  logic [NUM_DOORS-1:0] trip_q, trip_d;

  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_en;
  logic             t_zero;
  logic             any_door;

  assign any_door = |OpenDoorSign;

  alarm_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (t_load),
    .load_val(t_val),
    .en      (t_en),
    .zero    (t_zero)
  );

  always_comb begin
    state_d = state_q;
    trip_d  = trip_q;
    t_load  = 1'b0;
    t_val   = '0;
    t_en    = 1'b0;
    unique case (state_q)
      ST_DISARMED: begin
        if (ArmReq && !any_door && !IgnitionSignalOn) begin
          state_d = ST_ARMED;
          trip_d  = '0;
        end
      end
      ST_ARMED: begin
        if (IgnitionSignalOn) begin
          state_d = ST_ALARM;
          t_load  = 1'b1;
          t_val   = ALARM_LD;
        end else if (any_door) begin
          state_d = ST_ENTRY;
          t_load  = 1'b1;
          t_val   = ENTRY_LD;
          trip_d  = trip_q | OpenDoorSign;
        end
      end
      ST_ENTRY: begin
        trip_d = trip_q | OpenDoorSign;
        if (t_zero) begin
          state_d = ST_ALARM;
          t_load  = 1'b1;
          t_val   = ALARM_LD;
        end else begin
          t_en = 1'b1;
        end
      end
      ST_ALARM: begin
        trip_d = trip_q | OpenDoorSign;
        if (!t_zero) begin
          t_en = 1'b1;
        end else if (any_door || IgnitionSignalOn) begin
          t_load = 1'b1;
          t_val  = ALARM_LD;
        end else begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
    // Disarm wins; clear the timer so it idles at zero.
    if (DisarmReq) begin
      state_d = ST_DISARMED;
      t_load  = 1'b1;
      t_val   = '0;
    end
  end

  // Outputs follow the next state so they change with it.
  always_comb begin
    armed_d = (state_d != ST_DISARMED);
    warn_d  = (state_d == ST_DISARMED) &&
              CarLightsOnSign && any_door &&
              !IgnitionSignalOn;
`ifdef CAR_ALARM_PULSE_EN
    siren_d = (state_d == ST_ALARM) &&
              ((state_q != ST_ALARM) || !siren_q);
`else
    siren_d = (state_d == ST_ALARM);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DISARMED;
      siren_q <= 1'b0;
      warn_q  <= 1'b0;
      armed_q <= 1'b0;
      trip_q  <= '0;
    end else begin
      state_q <= state_d;
      siren_q <= siren_d;
      warn_q  <= warn_d;
      armed_q <= armed_d;
      trip_q  <= trip_d;
    end
  end

  assign CarAlarmSignal = siren_q;
  assign LightsWarning  = warn_q;
  assign Armed          = armed_q;
  assign TripDoor       = trip_q;

endmodule

// File: tb/tb_car_alarm_fsm.sv
// Directed bench for car_alarm_fsm.
// NUM_DOORS=4, ENTRY_DELAY=4, ALARM_LEN=6.
module tb_car_alarm_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       lights;
  logic [3:0] door;
  logic       ign;
  logic       arm;
  logic       disarm;
  logic       siren;
  logic       warn;
  logic       armed;
  logic [3:0] trip;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  car_alarm_fsm #(
    .NUM_DOORS  (4),
    .ENTRY_DELAY(4),
    .ALARM_LEN  (6)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .CarLightsOnSign (lights),
    .OpenDoorSign    (door),
    .IgnitionSignalOn(ign),
    .ArmReq          (arm),
    .DisarmReq       (disarm),
    .CarAlarmSignal  (siren),
    .LightsWarning   (warn),
    .Armed           (armed),
    .TripDoor        (trip)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, want %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected siren value on the i-th ALARM cycle.
  function automatic logic exp_siren(input int i);
`ifdef CAR_ALARM_PULSE_EN
    return (i % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    reset = 1; lights = 0; door = 0;
    ign = 0; arm = 0; disarm = 0;
    tick();
    reset = 0;
    chk("rst_siren", siren, 0);
    chk("rst_armed", armed, 0);
    chk("rst_warn", warn, 0);
    chk("rst_trip", trip, 0);

    // 1: arm blocked by open door / ignition
    door = 4'b0010; arm = 1;
    tick();
    chk("arm_door", armed, 0);
    door = 0; ign = 1;
    tick();
    chk("arm_ign", armed, 0);
    ign = 0; disarm = 1;
    tick();
    chk("arm_dis", armed, 0);
    disarm = 0;
    tick();
    arm = 0;
    chk("arm_ok", armed, 1);
    chk("arm_trip", trip, 0);

    // 2: entry then alarm
    door = 4'b0100;
    tick();
    door = 0;
    chk("ent_armed", armed, 1);
    chk("ent_siren0", siren, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("ent_siren", siren, 0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("alm_siren", siren, exp_siren(i));
    end
    chk("alm_trip", trip, 4'b0100);
    tick();
    chk("alm_end", siren, 0);
    chk("alm_end_arm", armed, 1);

    // 3: disarm during entry
    door = 4'b0100;
    tick();
    door = 0;
    tick();
    disarm = 1;
    tick();
    disarm = 0;
    chk("dis_armed", armed, 0);
    chk("dis_trip", trip, 4'b0100);
    for (int i = 0; i < 6; i++) tick();
    chk("dis_siren", siren, 0);

    // 4: ignition tamper with re-trigger
    arm = 1;
    tick();
    arm = 0;
    chk("ign_arm_trip", trip, 0);
    ign = 1;
    tick();
    chk("ign_siren0", siren, 1);
    chk("ign_trip", trip, 0);
    for (int i = 1; i <= 17; i++) begin
      tick();
      chk("ign_siren", siren, exp_siren(i));
      if (i == 13) ign = 0;
    end
    tick();
    chk("ign_end", siren, 0);
    chk("ign_end_arm", armed, 1);

    // 5: reset mid-alarm
    ign = 1; door = 4'b1000;
    tick();
    chk("rm_siren", siren, 1);
    ign = 0;
    tick();
    chk("rm_trip", trip, 4'b1000);
    reset = 1;
    tick();
    reset = 0; door = 0;
    chk("rm_siren0", siren, 0);
    chk("rm_armed0", armed, 0);
    chk("rm_trip0", trip, 0);

    // 6: lights warning
    lights = 1; door = 4'b0001;
    #1;
    chk("warn_pre", warn, 0);
    tick();
    chk("warn_on", warn, 1);
    ign = 1;
    tick();
    chk("warn_ign", warn, 0);
    ign = 0; lights = 0;
    tick();
    chk("warn_off", warn, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
